// File: rtl/bru_squash_arb_if.sv
// Signal bundle between the backend writeback/exception sources and the
// squash arbiter. The arbiter connects through the slave modport.
interface bru_squash_arb_if #(
  parameter int BRU_NUM  = 2,
  parameter int ROBIDX_W = 7,
  parameter int FTQIDX_W = 4,
  parameter int XLEN     = 64
);
  // branch writeback channels
  logic [BRU_NUM-1:0]  i_bwb_vld;
  logic [BRU_NUM-1:0]  i_bwb_mispred;
  logic [ROBIDX_W-1:0] i_bwb_robIdx [BRU_NUM];
  logic [FTQIDX_W-1:0] i_bwb_ftqIdx [BRU_NUM];
  logic [XLEN-1:0]     i_bwb_target [BRU_NUM];

  // exception writeback
  logic                i_except_vld;
  logic [ROBIDX_W-1:0] i_except_robIdx;
  logic [FTQIDX_W-1:0] i_except_ftqIdx;
  logic [XLEN-1:0]     i_except_target;

  // backend recovery complete pulse
  logic                i_recover_done;

  // squash request
  logic                o_squash_vld;
  logic [ROBIDX_W-1:0] o_squash_robIdx;
  logic [FTQIDX_W-1:0] o_squash_ftqIdx;
  logic [XLEN-1:0]     o_squash_target;
  logic                o_squash_except;

  // filtered branch writeback towards the FTQ
  logic [BRU_NUM-1:0]  o_bwb_vld;
  logic [ROBIDX_W-1:0] o_bwb_robIdx [BRU_NUM];
  logic [FTQIDX_W-1:0] o_bwb_ftqIdx [BRU_NUM];
  logic [XLEN-1:0]     o_bwb_target [BRU_NUM];
  logic [BRU_NUM-1:0]  o_bwb_mispred;

  // status
  logic                o_busy;
  logic [15:0]         o_squash_cnt;

  modport master (
    output i_bwb_vld, i_bwb_mispred, i_bwb_robIdx, i_bwb_ftqIdx, i_bwb_target,
    output i_except_vld, i_except_robIdx, i_except_ftqIdx, i_except_target,
    output i_recover_done,
    input  o_squash_vld, o_squash_robIdx, o_squash_ftqIdx, o_squash_target, o_squash_except,
    input  o_bwb_vld, o_bwb_robIdx, o_bwb_ftqIdx, o_bwb_target, o_bwb_mispred,
    input  o_busy, o_squash_cnt
  );

  modport slave (
    input  i_bwb_vld, i_bwb_mispred, i_bwb_robIdx, i_bwb_ftqIdx, i_bwb_target,
    input  i_except_vld, i_except_robIdx, i_except_ftqIdx, i_except_target,
    input  i_recover_done,
    output o_squash_vld, o_squash_robIdx, o_squash_ftqIdx, o_squash_target, o_squash_except,
    output o_bwb_vld, o_bwb_robIdx, o_bwb_ftqIdx, o_bwb_target, o_bwb_mispred,
    output o_busy, o_squash_cnt
  );
endinterface

// File: rtl/bru_squash_arb.sv
// Squash arbiter: picks the oldest mispredict/exception each cycle, issues a
// one-cycle squash pulse, and filters wrong-path branch writebacks while a
// squash recovery is in flight.
//
// state        | meaning
// ST_IDLE      | no squash outstanding; any winner issues
// ST_SQUASHING | squash outstanding at robIdx R; only strictly older winners issue
module bru_squash_arb #(
  parameter int BRU_NUM  = 2,
  parameter int ROBIDX_W = 7,
  parameter int FTQIDX_W = 4,
  parameter int XLEN     = 64
) (
  input logic             clk,
  input logic             rst,
  bru_squash_arb_if.slave bus
);

  localparam int IDX_W = ROBIDX_W - 1;

  typedef enum logic [0:0] {
    ST_IDLE      = 1'b0,
    ST_SQUASHING = 1'b1
  } state_e;

  // robIdx MSB is a wrap flag: same flag compares indices directly, a flipped
  // flag means the other operand has already wrapped.
  function automatic logic is_older(input logic [ROBIDX_W-1:0] a,
                                    input logic [ROBIDX_W-1:0] b);
    if (a[ROBIDX_W-1] == b[ROBIDX_W-1]) return a[IDX_W-1:0] < b[IDX_W-1:0];
    else                                 return a[IDX_W-1:0] > b[IDX_W-1:0];
  endfunction

  state_e              state_q, state_d;
  logic [ROBIDX_W-1:0] r_q, r_d;
  logic                r_live;
  logic                issue;

  logic                win_vld;
  logic [ROBIDX_W-1:0] win_rob;
  logic [FTQIDX_W-1:0] win_ftq;
  logic [XLEN-1:0]     win_tgt;
  logic                win_exc;

  logic                sq_vld_q;
  logic [ROBIDX_W-1:0] sq_rob_q;
  logic [FTQIDX_W-1:0] sq_ftq_q;
  logic [XLEN-1:0]     sq_tgt_q;
  logic                sq_exc_q;
  logic [15:0]         sq_cnt_q;

  logic [BRU_NUM-1:0]  bwb_vld_d, bwb_vld_q;
  logic [BRU_NUM-1:0]  bwb_mis_q;
  logic [ROBIDX_W-1:0] bwb_rob_q [BRU_NUM];
  logic [FTQIDX_W-1:0] bwb_ftq_q [BRU_NUM];
  logic [XLEN-1:0]     bwb_tgt_q [BRU_NUM];

  // Oldest-candidate select: lowest channel wins ties among branches, the
  // exception wins a tie against any branch.
  always_comb begin
    win_vld = 1'b0;
    win_rob = '0;
    win_ftq = '0;
    win_tgt = '0;
    win_exc = 1'b0;
    for (int i = 0; i < BRU_NUM; i++) begin
      if (bus.i_bwb_vld[i] && bus.i_bwb_mispred[i]) begin
        if (!win_vld || is_older(bus.i_bwb_robIdx[i], win_rob)) begin
          win_vld = 1'b1;
          win_rob = bus.i_bwb_robIdx[i];
          win_ftq = bus.i_bwb_ftqIdx[i];
          win_tgt = bus.i_bwb_target[i];
        end
      end
    end
    if (bus.i_except_vld && (!win_vld || !is_older(win_rob, bus.i_except_robIdx))) begin
      win_vld = 1'b1;
      win_rob = bus.i_except_robIdx;
      win_ftq = bus.i_except_ftqIdx;
      win_tgt = bus.i_except_target;
      win_exc = 1'b1;
    end
  end

  // State register and last-issued squash robIdx.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
    end
  end

  // Next state and issue decision. A recover_done pulse invalidates R for
  // this cycle, so a coincident winner issues regardless of its age.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    r_live  = 1'b0;
    issue   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        issue = win_vld;
        if (issue) begin
          state_d = ST_SQUASHING;
          r_d     = win_rob;
        end
      end
      ST_SQUASHING: begin
        r_live = !bus.i_recover_done;
        issue  = win_vld && (!r_live || is_older(win_rob, r_q));
        if (issue) begin
          r_d = win_rob;
        end else if (bus.i_recover_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Wrong-path filter: kill writebacks at/after the outstanding squash and
  // those strictly younger than this cycle's winner.
  always_comb begin
    bwb_vld_d = '0;
    for (int i = 0; i < BRU_NUM; i++) begin
      bwb_vld_d[i] = bus.i_bwb_vld[i]
                   && !(r_live && !is_older(bus.i_bwb_robIdx[i], r_q))
                   && !(win_vld && is_older(win_rob, bus.i_bwb_robIdx[i]));
    end
  end

  // Squash pulse and payload; payload holds between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sq_vld_q <= 1'b0;
      sq_rob_q <= '0;
      sq_ftq_q <= '0;
      sq_tgt_q <= '0;
      sq_exc_q <= 1'b0;
    end else begin
      sq_vld_q <= issue;
      if (issue) begin
        sq_rob_q <= win_rob;
        sq_ftq_q <= win_ftq;
        sq_tgt_q <= win_tgt;
        sq_exc_q <= win_exc;
      end
    end
  end

  // Saturating count of issued squash pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sq_cnt_q <= '0;
    end else if (sq_vld_q && (sq_cnt_q != 16'hFFFF)) begin
      sq_cnt_q <= sq_cnt_q + 16'd1;
    end
  end

  // Registered, filtered branch writeback; fields hold while valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bwb_vld_q <= '0;
      bwb_mis_q <= '0;
      for (int i = 0; i < BRU_NUM; i++) begin
        bwb_rob_q[i] <= '0;
        bwb_ftq_q[i] <= '0;
        bwb_tgt_q[i] <= '0;
      end
    end else begin
      bwb_vld_q <= bwb_vld_d;
      for (int i = 0; i < BRU_NUM; i++) begin
        if (bwb_vld_d[i]) begin
          bwb_mis_q[i] <= bus.i_bwb_mispred[i];
          bwb_rob_q[i] <= bus.i_bwb_robIdx[i];
          bwb_ftq_q[i] <= bus.i_bwb_ftqIdx[i];
          bwb_tgt_q[i] <= bus.i_bwb_target[i];
        end
      end
    end
  end

  assign bus.o_squash_vld    = sq_vld_q;
  assign bus.o_squash_robIdx = sq_rob_q;
  assign bus.o_squash_ftqIdx = sq_ftq_q;
  assign bus.o_squash_target = sq_tgt_q;
  assign bus.o_squash_except = sq_exc_q;
  assign bus.o_squash_cnt    = sq_cnt_q;
  assign bus.o_busy          = (state_q == ST_SQUASHING);
  assign bus.o_bwb_vld       = bwb_vld_q;
  assign bus.o_bwb_mispred   = bwb_mis_q;
  assign bus.o_bwb_robIdx    = bwb_rob_q;
  assign bus.o_bwb_ftqIdx    = bwb_ftq_q;
  assign bus.o_bwb_target    = bwb_tgt_q;

endmodule

// File: tb/tb_bru_squash_arb.sv
// Bench for bru_squash_arb: vector table with a scoreboard queue, plus
// hand-written reset and counter-saturation sequences.
module tb_bru_squash_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bru_squash_arb_if #(.BRU_NUM(2), .ROBIDX_W(7), .FTQIDX_W(4), .XLEN(64)) bus ();

  bru_squash_arb #(.BRU_NUM(2), .ROBIDX_W(7), .FTQIDX_W(4), .XLEN(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0] vld;
    logic [1:0] mis;
    logic [6:0] rob0;
    logic [6:0] rob1;
    logic       exc_vld;
    logic [6:0] exc_rob;
    logic       rec;
    logic       e_sq;
    int         e_src;   // 0/1 = branch channel, 2 = exception
    logic [1:0] e_bwb;
    logic       e_busy;
  } vec_t;

  typedef struct {
    logic        sq;
    logic [6:0]  rob;
    logic [3:0]  ftq;
    logic [63:0] tgt;
    logic        exc;
    logic [1:0]  bwb;
    logic        busy;
    logic [6:0]  brob0;
    logic [6:0]  brob1;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  logic [6:0]  h_rob = '0;
  logic [3:0]  h_ftq = '0;
  logic [63:0] h_tgt = '0;
  logic        h_exc = 1'b0;
  logic [6:0]  h_brob0 = '0;
  logic [6:0]  h_brob1 = '0;

  function automatic logic [6:0] rb(input int f, input int i);
    logic [31:0] fv, iv;
    fv = f;
    iv = i;
    return {fv[0], iv[5:0]};
  endfunction

  function automatic logic [3:0] ftq_of(input int src, input logic [6:0] r);
    return r[3:0] ^ 4'(src + 1);
  endfunction

  function automatic logic [63:0] tgt_of(input int src, input logic [6:0] r);
    return 64'h0000_1000_0000_0000 * 64'(src + 1) + 64'(r);
  endfunction

  function automatic vec_t mk(input logic [1:0] vld, input logic [1:0] mis,
                              input logic [6:0] r0, input logic [6:0] r1,
                              input logic ev, input logic [6:0] er, input logic rec,
                              input logic es, input int src, input logic [1:0] eb,
                              input logic ebusy);
    vec_t v;
    v.vld = vld; v.mis = mis; v.rob0 = r0; v.rob1 = r1;
    v.exc_vld = ev; v.exc_rob = er; v.rec = rec;
    v.e_sq = es; v.e_src = src; v.e_bwb = eb; v.e_busy = ebusy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] vld, input logic [1:0] mis,
                       input logic [6:0] r0, input logic [6:0] r1,
                       input logic ev, input logic [6:0] er, input logic rec);
    bus.i_bwb_vld       = vld;
    bus.i_bwb_mispred   = mis;
    bus.i_bwb_robIdx[0] = r0;
    bus.i_bwb_robIdx[1] = r1;
    bus.i_bwb_ftqIdx[0] = ftq_of(0, r0);
    bus.i_bwb_ftqIdx[1] = ftq_of(1, r1);
    bus.i_bwb_target[0] = tgt_of(0, r0);
    bus.i_bwb_target[1] = tgt_of(1, r1);
    bus.i_except_vld    = ev;
    bus.i_except_robIdx = er;
    bus.i_except_ftqIdx = ftq_of(2, er);
    bus.i_except_target = tgt_of(2, er);
    bus.i_recover_done  = rec;
  endtask

  task automatic drive_idle();
    drive(2'b00, 2'b00, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic apply_vec(input vec_t v);
    exp_t e;
    logic [6:0] srob;
    drive(v.vld, v.mis, v.rob0, v.rob1, v.exc_vld, v.exc_rob, v.rec);
    if (v.e_sq) begin
      srob  = (v.e_src == 0) ? v.rob0 : (v.e_src == 1) ? v.rob1 : v.exc_rob;
      h_rob = srob;
      h_ftq = ftq_of(v.e_src, srob);
      h_tgt = tgt_of(v.e_src, srob);
      h_exc = (v.e_src == 2);
    end
    if (v.e_bwb[0]) h_brob0 = v.rob0;
    if (v.e_bwb[1]) h_brob1 = v.rob1;
    e.sq = v.e_sq; e.rob = h_rob; e.ftq = h_ftq; e.tgt = h_tgt; e.exc = h_exc;
    e.bwb = v.e_bwb; e.busy = v.e_busy; e.brob0 = h_brob0; e.brob1 = h_brob1;
    sb.push_back(e);
  endtask

  task automatic check_out(input int n);
    exp_t e;
    string t;
    if (sb.size() == 0) begin
      chk($sformatf("v%0d scoreboard_nonempty", n), 64'd0, 64'd1);
      return;
    end
    e = sb.pop_front();
    t = $sformatf("v%0d", n);
    chk({t, " sq_vld"},  64'(bus.o_squash_vld),    64'(e.sq));
    chk({t, " sq_rob"},  64'(bus.o_squash_robIdx), 64'(e.rob));
    chk({t, " sq_ftq"},  64'(bus.o_squash_ftqIdx), 64'(e.ftq));
    chk({t, " sq_tgt"},  bus.o_squash_target,      e.tgt);
    chk({t, " sq_exc"},  64'(bus.o_squash_except), 64'(e.exc));
    chk({t, " bwb_vld"}, 64'(bus.o_bwb_vld),       64'(e.bwb));
    chk({t, " busy"},    64'(bus.o_busy),          64'(e.busy));
    chk({t, " bwb_rob0"}, 64'(bus.o_bwb_robIdx[0]), 64'(e.brob0));
    chk({t, " bwb_rob1"}, 64'(bus.o_bwb_robIdx[1]), 64'(e.brob1));
  endtask

  initial begin
    //                vld    mis    rob0      rob1      ev  erob      rec  sq src bwb   busy
    tbl.push_back(mk(2'b00, 2'b00, rb(0,0),  rb(0,0),  0, rb(0,0),  0,   0, 0, 2'b00, 0)); // idle
    tbl.push_back(mk(2'b11, 2'b11, rb(0,5),  rb(0,3),  0, rb(0,0),  0,   1, 1, 2'b10, 1)); // oldest of two
    tbl.push_back(mk(2'b00, 2'b00, rb(0,0),  rb(0,0),  0, rb(0,0),  0,   0, 0, 2'b00, 1));
    tbl.push_back(mk(2'b00, 2'b00, rb(0,0),  rb(0,0),  0, rb(0,0),  1,   0, 0, 2'b00, 0)); // recover
    tbl.push_back(mk(2'b11, 2'b11, rb(1,1),  rb(0,60), 0, rb(0,0),  0,   1, 1, 2'b10, 1)); // wrap
    tbl.push_back(mk(2'b00, 2'b00, rb(0,0),  rb(0,0),  0, rb(0,0),  1,   0, 0, 2'b00, 0));
    tbl.push_back(mk(2'b01, 2'b01, rb(0,10), rb(0,0),  0, rb(0,0),  0,   1, 0, 2'b01, 1)); // R=10
    tbl.push_back(mk(2'b01, 2'b01, rb(0,12), rb(0,0),  0, rb(0,0),  0,   0, 0, 2'b00, 1)); // younger dropped
    tbl.push_back(mk(2'b10, 2'b00, rb(0,0),  rb(0,12), 0, rb(0,0),  0,   0, 0, 2'b00, 1)); // wrong path wb
    tbl.push_back(mk(2'b10, 2'b10, rb(0,0),  rb(0,8),  0, rb(0,0),  0,   1, 1, 2'b10, 1)); // older, R=8
    tbl.push_back(mk(2'b11, 2'b00, rb(0,9),  rb(0,7),  0, rb(0,0),  0,   0, 0, 2'b10, 1)); // filter vs R
    tbl.push_back(mk(2'b01, 2'b01, rb(0,20), rb(0,0),  0, rb(0,0),  1,   1, 0, 2'b01, 1)); // recover+younger
    tbl.push_back(mk(2'b01, 2'b01, rb(0,20), rb(0,0),  0, rb(0,0),  0,   0, 0, 2'b00, 1)); // equal R dropped
    tbl.push_back(mk(2'b00, 2'b00, rb(0,0),  rb(0,0),  0, rb(0,0),  1,   0, 0, 2'b00, 0));
    tbl.push_back(mk(2'b01, 2'b01, rb(0,4),  rb(0,0),  1, rb(0,4),  0,   1, 2, 2'b01, 1)); // exc wins tie
    tbl.push_back(mk(2'b00, 2'b00, rb(0,0),  rb(0,0),  0, rb(0,0),  1,   0, 0, 2'b00, 0));
    tbl.push_back(mk(2'b00, 2'b00, rb(0,0),  rb(0,0),  0, rb(0,0),  1,   0, 0, 2'b00, 0)); // recover in idle
    tbl.push_back(mk(2'b11, 2'b11, rb(0,2),  rb(0,2),  0, rb(0,0),  0,   1, 0, 2'b11, 1)); // lowest ch tie
    tbl.push_back(mk(2'b10, 2'b10, rb(0,0),  rb(0,1),  1, rb(0,30), 0,   1, 1, 2'b10, 1)); // branch older than exc
    tbl.push_back(mk(2'b00, 2'b00, rb(0,0),  rb(0,0),  1, rb(0,0),  0,   1, 2, 2'b00, 1)); // exc older than R
    tbl.push_back(mk(2'b00, 2'b00, rb(0,0),  rb(0,0),  0, rb(0,0),  1,   0, 0, 2'b00, 0));

    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset sq_vld", 64'(bus.o_squash_vld), 64'd0);
    chk("reset busy",   64'(bus.o_busy),       64'd0);
    chk("reset bwb",    64'(bus.o_bwb_vld),    64'd0);
    chk("reset cnt",    64'(bus.o_squash_cnt), 64'd0);
    chk("reset rob",    64'(bus.o_squash_robIdx), 64'd0);
    rst = 1'b0;

    for (int n = 0; n < tbl.size(); n++) begin
      apply_vec(tbl[n]);
      @(posedge clk);
      #1;
      check_out(n);
    end
    drive_idle();
    @(posedge clk);
    #1;
    chk("table sq_cnt", 64'(bus.o_squash_cnt), 64'd9);

    // reset while squashing: inputs during reset ignored, squash right after
    drive(2'b01, 2'b01, rb(0,5), '0, 1'b0, '0, 1'b0);
    @(posedge clk);
    #1;
    chk("pre-rst sq_vld", 64'(bus.o_squash_vld), 64'd1);
    chk("pre-rst busy",   64'(bus.o_busy),       64'd1);
    drive(2'b01, 2'b01, rb(0,3), '0, 1'b0, '0, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst async busy",   64'(bus.o_busy),       64'd0);
    chk("rst async sq_vld", 64'(bus.o_squash_vld), 64'd0);
    chk("rst async cnt",    64'(bus.o_squash_cnt), 64'd0);
    chk("rst async rob",    64'(bus.o_squash_robIdx), 64'd0);
    @(posedge clk);
    #1;
    chk("in-rst sq_vld", 64'(bus.o_squash_vld), 64'd0);
    chk("in-rst busy",   64'(bus.o_busy),       64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post-rst sq_vld", 64'(bus.o_squash_vld),    64'd1);
    chk("post-rst rob",    64'(bus.o_squash_robIdx), 64'(rb(0,3)));
    chk("post-rst busy",   64'(bus.o_busy),          64'd1);
    drive(2'b00, 2'b00, '0, '0, 1'b0, '0, 1'b1);
    @(posedge clk);
    #1;
    chk("post-rst recover busy", 64'(bus.o_busy),       64'd0);
    chk("post-rst cnt",          64'(bus.o_squash_cnt), 64'd1);

    // counter saturation: recover_done plus a winner issues every cycle
    drive(2'b01, 2'b01, rb(0,3), '0, 1'b0, '0, 1'b1);
    repeat (65534) @(posedge clk);
    #1;
    drive(2'b00, 2'b00, '0, '0, 1'b0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("preload cnt",  64'(bus.o_squash_cnt), 64'hFFFF);
    chk("preload busy", 64'(bus.o_busy),       64'd1);
    drive(2'b01, 2'b01, rb(0,3), '0, 1'b0, '0, 1'b1);
    @(posedge clk);
    #1;
    chk("extra sq_vld", 64'(bus.o_squash_vld), 64'd1);
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("saturated cnt", 64'(bus.o_squash_cnt), 64'hFFFF);
    rst = 1'b1;
    #1;
    chk("final rst busy", 64'(bus.o_busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bru_squash_arb.md
BRU_SQUASH_ARB -- requirements
Module: bru_squash_arb

Interface
REQ-001 SHALL have parameter BRU_NUM, default 2, number of branch writeback channels (1..8).
REQ-002 SHALL have parameter ROBIDX_W, default 7, robIdx width: MSB is the wrap flag, remaining bits are the index.
REQ-003 SHALL have parameter FTQIDX_W, default 4, ftqIdx width.
REQ-004 SHALL have parameter XLEN, default 64, target address width.
REQ-005 SHALL have port clk, input, 1, sole clock.
REQ-006 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-007 SHALL have port i_bwb_vld, input, BRU_NUM, per-channel branch writeback valid.
REQ-008 SHALL have port i_bwb_mispred, input, BRU_NUM, per-channel mispredict flag; qualified by i_bwb_vld.
REQ-009 SHALL have ports i_bwb_robIdx[BRU_NUM], i_bwb_ftqIdx[BRU_NUM] and i_bwb_target[BRU_NUM], inputs, ROBIDX_W/FTQIDX_W/XLEN each, per-channel writeback info.
REQ-010 SHALL have port i_except_vld, input, 1, exception writeback valid.
REQ-011 SHALL have ports i_except_robIdx, i_except_ftqIdx and i_except_target, inputs, exception info.
REQ-012 SHALL have port i_recover_done, input, 1, one-cycle pulse from the backend marking squash recovery complete.
REQ-013 SHALL have port o_squash_vld, output, 1, one-cycle squash pulse.
REQ-014 SHALL have ports o_squash_robIdx, o_squash_ftqIdx, o_squash_target and o_squash_except, outputs, squash info; o_squash_except=1 when the source is an exception.
REQ-015 SHALL have port o_bwb_vld, output, BRU_NUM, filtered branch writeback valid to the FTQ.
REQ-016 SHALL have ports o_bwb_robIdx, o_bwb_ftqIdx, o_bwb_target and o_bwb_mispred, outputs, per-channel registered copies of the inputs.
REQ-017 SHALL have port o_busy, output, 1, high while the FSM is in SQUASHING.
REQ-018 SHALL have port o_squash_cnt, output, 16, saturating count of issued squashes.

Function
REQ-019 Age compare SHALL be: A older than B iff flags are equal ? idxA<idxB : idxA>idxB; equal robIdx means same instruction.
REQ-020 Each cycle, candidates SHALL be every channel with vld&mispred plus the exception if valid; the oldest candidate wins.
REQ-021 On equal robIdx the exception SHALL win; among equal branch channels the lowest channel index SHALL win.
REQ-022 The FSM SHALL have two states, IDLE and SQUASHING, with register R holding the robIdx of the last issued squash.
REQ-023 In IDLE, a winner SHALL cause o_squash_vld=1 with the winner's info in the next cycle (latency 1), load R, and move the FSM to SQUASHING.
REQ-024 In SQUASHING, a winner strictly older than R SHALL issue a new squash (latency 1) and update R; a winner equal to or younger than R SHALL be dropped.
REQ-025 i_recover_done in SQUASHING SHALL move the FSM to IDLE; in IDLE it SHALL be ignored.
REQ-026 If i_recover_done coincides with an older winner, the squash SHALL issue and the FSM SHALL stay in SQUASHING.
REQ-027 If i_recover_done coincides with a younger or equal winner, the winner SHALL be compared against an invalidated R and therefore issue, leaving the FSM in SQUASHING.
REQ-028 o_bwb_vld[i] SHALL be i_bwb_vld[i] registered by one cycle, forced to 0 when the FSM is in SQUASHING and robIdx[i] is equal to or younger than R (wrong path).
REQ-029 The o_bwb filter SHALL also apply same-cycle: a channel younger than this cycle's winner SHALL be suppressed.
REQ-030 o_squash_cnt SHALL increment on each o_squash_vld and saturate at 16'hFFFF.
REQ-031 Squash and o_bwb output fields SHALL hold their last values when the corresponding valid is low.

Reset
REQ-032 On rst high, asynchronously: FSM=IDLE; o_squash_vld=0, o_bwb_vld=0, o_busy=0; o_squash_cnt=0; R and all data outputs=0.
REQ-033 Inputs present during the reset cycle SHALL be ignored, and the first squash SHALL be possible the cycle after rst falls.
REQ-034 Reset asserted mid-SQUASHING SHALL abort to IDLE with no further squash pulse.

Verification
REQ-035 Ch0 {f0,idx5} mispredict and ch1 {f0,idx3} mispredict in the same cycle T -> at T+1 one pulse with robIdx 3; o_bwb_vld=2'b10.
REQ-036 Wrap case: ch0 {f1,idx1} and ch1 {f0,idx60} -> squash robIdx {f0,60}.
REQ-037 In SQUASHING with R=10: a mispredict with robIdx 12 is dropped (no pulse, o_bwb_vld=0); a later mispredict with robIdx 8 pulses and sets R=8.
REQ-038 Exception {f0,4} plus ch0 mispredict {f0,4} -> o_squash_except=1 with the exception target.
REQ-039 i_recover_done plus a robIdx-20 mispredict with R=10 -> pulse issued, o_busy stays 1.
REQ-040 Preload 65535 squashes, then issue one more -> o_squash_cnt stays 16'hFFFF; rst mid-SQUASHING -> o_busy=0 immediately.
